// File: rtl/pwm_pkg.sv
// Shared constants and channel-state encoding for the PWM capture block.
package pwm_pkg;

  localparam int unsigned MAX_CH    = 8;
  localparam int unsigned CH_STRIDE = 12;

  localparam logic [6:0] ADR_CTRL   = 7'h00;
  localparam logic [6:0] ADR_PERIOD = 7'h04;
  localparam logic [6:0] ADR_HIGH   = 7'h08;
  localparam logic [6:0] ADR_STATUS = 7'h60;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } ch_state_e;

  // Byte address of a per-channel register.
  function automatic logic [6:0] ch_adrs(input int unsigned ch, input logic [6:0] ofs);
    return 7'(ch * CH_STRIDE) + ofs;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Register bus shared with the PWM generator: rd/wr strobes, byte address, data.
interface pwm_capture_if;
  logic        rd;
  logic        wr;
  logic [6:0]  adrs;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output rd, output wr, output adrs, output din, input dout);
  modport slave  (input rd, input wr, input adrs, input din, output dout);
endinterface

// File: rtl/pwm_capture_ch.sv
// One capture channel: input synchronizer, edge detect, measurement FSM,
// running counters and the PERIOD/HIGH result registers.
module pwm_capture_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CW = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pwm,
  input  logic        i_en,
  output logic [31:0] o_period,
  output logic [31:0] o_high,
  output logic        o_valid_set,
  output logic        o_ovf_set
);

  logic          r_s1, r_s2, r_s3;
  logic          w_rise, w_fall;
  ch_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_hi, w_hi_nxt;
  logic [CW-1:0] r_period, r_high;
  logic          w_latch;

  // Two-flop synchronizer followed by the edge register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_pwm;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  // Channel state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, counter updates and event pulses; a rise takes priority over overflow.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_latch     = 1'b0;
    o_valid_set = 1'b0;
    o_ovf_set   = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_hi_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ARM;
          w_cnt_nxt   = '0;
        end
        ST_ARM: begin
          if (w_rise) begin
            w_state_nxt = ST_MEAS;
            w_cnt_nxt   = CW'(1);
          end
        end
        ST_MEAS: begin
          if (w_rise) begin
            w_latch     = 1'b1;
            o_valid_set = 1'b1;
            w_cnt_nxt   = CW'(1);
          end else if (r_cnt == '1) begin
            o_ovf_set   = 1'b1;
            w_state_nxt = ST_ARM;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_fall) w_hi_nxt = r_cnt;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Running counters and latched results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_period <= '0;
      r_high   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_hi  <= w_hi_nxt;
      if (w_latch) begin
        r_period <= r_cnt;
        r_high   <= r_hi;
      end
    end
  end

  assign o_period = 32'(r_period);
  assign o_high   = 32'(r_high);

endmodule

// File: rtl/pwm_capture.sv
// PWM capture top: CTRL/STATUS registers, address decode, registered read mux,
// and one capture channel per implemented input.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned NCH = 8,
  parameter int unsigned CW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  pwm_capture_if.slave   bus,
  input  logic [NCH-1:0] pwmi
);

  logic [MAX_CH-1:0] r_en;
  logic [MAX_CH-1:0] r_valid, r_ovf;
  logic [MAX_CH-1:0] w_valid_set, w_ovf_set;
  logic [MAX_CH-1:0] w_valid_clr, w_ovf_clr;
  logic [31:0]       w_period [MAX_CH];
  logic [31:0]       w_high   [MAX_CH];
  logic [31:0]       w_rdata;
  logic [31:0]       r_dout;
  logic              w_wr_status;
  logic              w_unused_din;

  for (genvar n = 0; n < MAX_CH; n++) begin : g_ch
    if (n < NCH) begin : g_on
      pwm_capture_ch #(.CW(CW)) u_ch (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_pwm       (pwmi[n]),
        .i_en        (r_en[n]),
        .o_period    (w_period[n]),
        .o_high      (w_high[n]),
        .o_valid_set (w_valid_set[n]),
        .o_ovf_set   (w_ovf_set[n])
      );
    end else begin : g_off
      assign w_period[n]    = '0;
      assign w_high[n]      = '0;
      assign w_valid_set[n] = 1'b0;
      assign w_ovf_set[n]   = 1'b0;
    end
  end

  assign w_wr_status  = bus.wr && (bus.adrs == ADR_STATUS);
  assign w_valid_clr  = w_wr_status ? bus.din[MAX_CH-1:0] : '0;
  assign w_ovf_clr    = w_wr_status ? bus.din[8 +: MAX_CH] : '0;
  assign w_unused_din = ^bus.din[31:16];

  // Per-channel enable bits; writes to unimplemented channels are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en <= '0;
    end else begin
      for (int unsigned n = 0; n < MAX_CH; n++) begin
        if (bus.wr && (n < NCH) && (bus.adrs == ch_adrs(n, ADR_CTRL))) r_en[n] <= bus.din[0];
      end
    end
  end

  // Sticky status flags: W1C clear, with a same-cycle hardware set winning.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_ovf   <= '0;
    end else begin
      r_valid <= (r_valid & ~w_valid_clr) | w_valid_set;
      r_ovf   <= (r_ovf   & ~w_ovf_clr)   | w_ovf_set;
    end
  end

  // Read decode; unmapped and unaligned addresses return zero.
  always_comb begin
    w_rdata = '0;
    if (bus.adrs == ADR_STATUS) w_rdata = 32'({r_ovf, r_valid});
    for (int unsigned n = 0; n < MAX_CH; n++) begin
      if (n < NCH) begin
        if (bus.adrs == ch_adrs(n, ADR_CTRL))   w_rdata = {31'h0, r_en[n]};
        if (bus.adrs == ch_adrs(n, ADR_PERIOD)) w_rdata = w_period[n];
        if (bus.adrs == ch_adrs(n, ADR_HIGH))   w_rdata = w_high[n];
      end
    end
  end

  // Registered read data, loaded only on rd; a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_dout <= '0;
    else if (bus.rd) r_dout <= w_rdata;
  end

  assign bus.dout = r_dout;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a CW=32 instance for the main tests and a
// CW=8 instance for the overflow test. Inputs change on the falling edge.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_capture_if bus ();
  pwm_capture_if bus8 ();

  logic [15:0] g_out = '0;
  int unsigned g_per [16];
  int unsigned g_hi  [16];
  int unsigned g_ph  [16];
  bit          g_lvl [16];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pwm_capture #(.NCH(8), .CW(32)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .pwmi (g_out[7:0])
  );

  pwm_capture #(.NCH(8), .CW(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus8),
    .pwmi (g_out[15:8])
  );

  // Clock-synchronous PWM sources: period 0 means hold the static level.
  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (g_per[i] == 0) begin
        g_out[i] = g_lvl[i];
      end else begin
        g_out[i] = (g_ph[i] < g_hi[i]);
        g_ph[i]  = (g_ph[i] + 1 >= g_per[i]) ? 0 : g_ph[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input bit d8, input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    if (d8) begin bus8.wr = 1'b1; bus8.adrs = a; bus8.din = d; end
    else    begin bus.wr  = 1'b1; bus.adrs  = a; bus.din  = d; end
    @(negedge clk);
    bus.wr  = 1'b0;
    bus8.wr = 1'b0;
  endtask

  task automatic bus_rd(input bit d8, input logic [6:0] a, output logic [31:0] v);
    @(negedge clk);
    if (d8) begin bus8.rd = 1'b1; bus8.adrs = a; end
    else    begin bus.rd  = 1'b1; bus.adrs  = a; end
    @(negedge clk);
    bus.rd  = 1'b0;
    bus8.rd = 1'b0;
    v = d8 ? bus8.dout : bus.dout;
  endtask

  task automatic rd_chk(input bit d8, input logic [6:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    bus_rd(d8, a, v);
    check(tag, v, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int unsigned k;
    bit          found;

    bus.rd = 0;  bus.wr = 0;  bus.adrs = '0;  bus.din = '0;
    bus8.rd = 0; bus8.wr = 0; bus8.adrs = '0; bus8.din = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_dout8", bus8.dout, 32'h0);
    rst = 1'b1;
    for (int a = 0; a <= 96; a += 4) rd_chk(0, 7'(a), 32'h0, $sformatf("rst_rd_%02h", a));

    // Basic measurement on ch0: period 10, high 3
    bus_wr(0, 7'h00, 32'h1);
    rd_chk(0, 7'h00, 32'h1, "ctrl0");
    g_hi[0] = 3; g_ph[0] = 0; g_per[0] = 10;
    repeat (40) @(negedge clk);
    rd_chk(0, 7'h04, 32'd10, "period0");
    rd_chk(0, 7'h08, 32'd3, "high0");
    rd_chk(0, 7'h60, 32'h1, "status_ch0");
    g_lvl[0] = 0; g_per[0] = 0;
    repeat (20) @(negedge clk);
    bus_wr(0, 7'h60, 32'h1);
    rd_chk(0, 7'h60, 32'h0, "status_w1c");
    rd_chk(0, 7'h04, 32'd10, "period0_kept");

    // All channels: period 20+n, high 5+n
    for (int n = 0; n < 8; n++) begin
      g_hi[n] = 5 + n; g_ph[n] = 0; g_per[n] = 20 + n;
    end
    for (int n = 0; n < 8; n++) bus_wr(0, 7'(12 * n), 32'h1);
    repeat (150) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      rd_chk(0, 7'(12 * n + 4), 32'(20 + n), $sformatf("period%0d", n));
      rd_chk(0, 7'(12 * n + 8), 32'(5 + n), $sformatf("high%0d", n));
    end
    rd_chk(0, 7'h60, 32'h0000_00FF, "status_all");

    // Disable ch1 mid-period, re-enable 50 clks later with period 8 / high 4
    k = 0;
    while (g_ph[1] != 10 && k < 100) begin @(negedge clk); k++; end
    check("ch1_phase_wait", 32'(k < 100), 32'h1);
    bus_wr(0, 7'h0C, 32'h0);
    g_hi[1] = 4; g_ph[1] = 0; g_per[1] = 8;
    rd_chk(0, 7'h10, 32'd21, "period1_held");
    rd_chk(0, 7'h14, 32'd6, "high1_held");
    rd_chk(0, 7'h0C, 32'h0, "ctrl1_off");
    repeat (38) @(negedge clk);
    bus_wr(0, 7'h60, 32'h2);
    rd_chk(0, 7'h60, 32'h0000_00FD, "status_clr1");
    bus_wr(0, 7'h0C, 32'h1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      bus_rd(0, 7'h60, v);
      if (v[1]) found = 1;
    end
    check("ch1_revalid", 32'(found), 32'h1);
    rd_chk(0, 7'h10, 32'd8, "period1_new");
    rd_chk(0, 7'h14, 32'd4, "high1_new");

    // Overflow on the CW=8 instance, ch2
    bus_wr(1, 7'h18, 32'h1);
    g_hi[10] = 5; g_ph[10] = 0; g_per[10] = 10;
    repeat (50) @(negedge clk);
    rd_chk(1, 7'h1C, 32'd10, "ovf_period2_pre");
    rd_chk(1, 7'h20, 32'd5, "ovf_high2_pre");
    k = 0;
    while (g_ph[10] != 2 && k < 50) begin @(negedge clk); k++; end
    check("ch2_phase_wait", 32'(k < 50), 32'h1);
    g_lvl[10] = 1; g_per[10] = 0;
    repeat (200) @(negedge clk);
    rd_chk(1, 7'h60, 32'h0000_0004, "ovf_not_yet");
    repeat (100) @(negedge clk);
    rd_chk(1, 7'h60, 32'h0000_0404, "ovf_set");
    rd_chk(1, 7'h1C, 32'd10, "ovf_period2_kept");
    rd_chk(1, 7'h20, 32'd5, "ovf_high2_kept");
    g_hi[10] = 6; g_ph[10] = 0; g_per[10] = 12;
    repeat (60) @(negedge clk);
    rd_chk(1, 7'h1C, 32'd12, "ovf_period2_resume");
    rd_chk(1, 7'h20, 32'd6, "ovf_high2_resume");
    bus_wr(1, 7'h60, 32'h400);
    rd_chk(1, 7'h60, 32'h0000_0004, "ovf_w1c");

    // Bus corner cases
    bus_wr(0, 7'h24, 32'h0);
    @(negedge clk);
    bus.wr = 1'b1; bus.rd = 1'b1; bus.adrs = 7'h24; bus.din = 32'h1;
    @(negedge clk);
    bus.wr = 1'b0; bus.rd = 1'b0;
    check("wr_rd_same", bus.dout, 32'h0);
    rd_chk(0, 7'h24, 32'h1, "ctrl3_after");
    rd_chk(0, 7'h7C, 32'h0, "unmapped_7c");
    rd_chk(0, 7'h01, 32'h0, "unaligned_01");
    bus_wr(0, 7'h7C, 32'hFFFF_FFFF);
    rd_chk(0, 7'h60, 32'h0000_00FF, "status_after_unmapped_wr");
    rd_chk(0, 7'h04, 32'd20, "period0_pre_rst");

    // Asynchronous reset mid-measurement
    #2 rst = 1'b0;
    #1 check("rst_async_dout", bus.dout, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd_chk(0, 7'h04, 32'h0, "rst_period0");
    rd_chk(0, 7'h08, 32'h0, "rst_high0");
    rd_chk(0, 7'h60, 32'h0, "rst_status");
    rd_chk(0, 7'h00, 32'h0, "rst_ctrl0");
    rd_chk(1, 7'h1C, 32'h0, "rst_period2_cw8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
